// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: FSM encodings and port indices shared by the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} arb_state_t;
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU = 1'b1;
endpackage

// File: rtl/_32bit_2_1mux.sv
// _32bit_2_1mux: 32-bit 2:1 steering mux cell
module _32bit_2_1mux (
  input  logic        sel,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic [31:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// File: rtl/mem_port_arbiter_rr_streak_pick.sv
// rr_streak_pick: picks the next owner and the updated consecutive-grant streak
module rr_streak_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int PRIO_PORT  = 1,
  parameter int MAX_STREAK = 4,
  parameter int STREAK_W   = 3
) (
  input  logic                req0,
  input  logic                req1,
  input  logic                last_owner,
  input  logic [STREAK_W-1:0] streak,
  output logic                any,
  output logic                winner,
  output logic [STREAK_W-1:0] next_streak
);
  always_comb begin
    any = req0 | req1;
    winner = (req0 & req1) ? ((streak >= STREAK_W'(MAX_STREAK)) ? ~last_owner : 1'(PRIO_PORT))
                           : (req1 ? PORT_LSU : PORT_FETCH);
    next_streak = (winner != last_owner) ? STREAK_W'(1) : ((&streak) ? streak : streak + 1'b1);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (port 0) and load/store (port 1)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int PRIO_PORT   = 1,
  parameter int MAX_STREAK  = 4,
  parameter int STREAK_W    = 3,
  parameter int TIMEOUT_CYC = 16,
  parameter int TMR_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic        we1,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        sel,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err
);
  arb_state_t state, nxt;
  logic [STREAK_W-1:0] streak, next_streak;
  logic [TMR_W-1:0] timer;
  logic any, winner, busy, tmo;
  rr_streak_pick #(
    .PRIO_PORT(PRIO_PORT),
    .MAX_STREAK(MAX_STREAK),
    .STREAK_W(STREAK_W)
  ) u_pick (
    .req0(req0),
    .req1(req1),
    .last_owner(sel),
    .streak(streak),
    .any(any),
    .winner(winner),
    .next_streak(next_streak)
  );
  // sel doubles as last_owner: both are loaded with the winner at every grant
  always_comb begin
    busy = state != IDLE;
    tmo = busy & ~mem_ack & (timer == TMR_W'(TIMEOUT_CYC - 1));
    nxt = !busy ? (any ? (winner ? GRANT1 : GRANT0) : IDLE) : ((mem_ack | tmo) ? IDLE : state);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= PORT_FETCH;
      streak <= '0;
      timer <= '0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      err <= tmo;
      timer <= (nxt == IDLE || !busy) ? '0 : timer + 1'b1;
      if (!busy && any) begin
        sel <= winner;
        streak <= next_streak;
      end
    end
  end
  assign gnt0 = state == GRANT0;
  assign gnt1 = state == GRANT1;
  assign mem_req = gnt0 | gnt1;
  assign mem_we = we1 & gnt1;
  assign done0 = gnt0 & mem_ack;
  assign done1 = gnt1 & mem_ack;
  _32bit_2_1mux u_addr_mux (.sel(sel), .in0(addr0), .in1(addr1), .out(mem_addr));
  _32bit_2_1mux u_wdata_mux (.sel(sel), .in0(32'b0), .in1(wdata1), .out(mem_wdata));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int MAXS = 2;
  localparam int TMO = 8;
  logic clk = 0, rst_n = 0, req0 = 0, req1 = 0, we1 = 0, mem_ack = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata1 = 0;
  logic mem_req, mem_we, sel, gnt0, gnt1, done0, done1, err;
  logic [31:0] mem_addr, mem_wdata;
  mem_port_arbiter #(
    .PRIO_PORT(1), .MAX_STREAK(MAXS), .STREAK_W(3), .TIMEOUT_CYC(TMO), .TMR_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .wdata1(wdata1), .we1(we1), .mem_ack(mem_ack), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .sel(sel), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit port;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit we;
    int d;
  } exp_t;
  exp_t sbq[$];
  int vectors = 0, miscompares = 0;
  bit mon_en = 0, prev_g = 0;
  int gcyc = 0;
  int last_owner = 0, run = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Monitor: checks each new grant, then resolves it on done or err
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if ((gnt0 | gnt1) && !prev_g) begin
        if (sbq.size() == 0) chk("unexpected_grant", 1, 0);
        else begin
          e = sbq[0];
          chk("gnt1", gnt1, e.port);
          chk("gnt0", gnt0, !e.port);
          chk("sel", sel, e.port);
          chk("mem_req", mem_req, 1);
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wdata", mem_wdata, e.wdata);
          chk("mem_we", mem_we, e.we);
        end
        gcyc = 0;
      end
      if (gnt0 | gnt1) gcyc++;
      if (done0 | done1 | err) begin
        if (sbq.size() == 0) chk("spurious_done_err", 1, 0);
        else begin
          e = sbq.pop_front();
          if (err) begin
            chk("err_expected", e.d >= TMO, 1);
            chk("timeout_len", gcyc, TMO);
          end else begin
            chk("done_port", done1, e.port);
            chk("done_expected", e.d < TMO, 1);
            chk("ack_len", gcyc, e.d + 1);
          end
        end
      end
      prev_g = gnt0 | gnt1;
    end
  end
  task automatic run_rounds(input int n);
    bit p0 = 0, p1 = 0, w;
    int d;
    for (int r = 0; r < n; r++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1;
        addr0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1;
        addr1 = $urandom;
        wdata1 = $urandom;
        we1 = 1'($urandom);
      end
      mem_ack = $urandom_range(0, 3) == 0;
      req0 = p0;
      req1 = p1;
      if (!p0 && !p1) begin
        tick;
        continue;
      end
      if (p0 && p1) w = (run >= MAXS) ? (last_owner == 0) : 1'b1;
      else w = p1;
      run = (int'(w) == last_owner) ? run + 1 : 1;
      last_owner = int'(w);
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 1, TMO + 1) : $urandom_range(0, 5);
      sbq.push_back('{w, w ? addr1 : addr0, w ? wdata1 : 32'b0, w & we1, d});
      tick;
      if (w) begin
        p1 = 0;
        req1 = 0;
      end else begin
        p0 = 0;
        req0 = 0;
      end
      for (int k = 0; k < TMO; k++) begin
        mem_ack = (k == d);
        tick;
        if (k == d) break;
      end
      mem_ack = 0;
    end
    req0 = 0;
    req1 = 0;
    tick;
    tick;
  endtask
  initial begin
    rst_n = 0;
    req0 = 1;
    req1 = 1;
    mem_ack = 1;
    tick;
    tick;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_err", err, 0);
    chk("rst_sel", sel, 0);
    chk("rst_done", done0 | done1, 0);
    rst_n = 1;
    mem_ack = 0;
    tick;
    chk("first_grant_gnt1", gnt1, 1);
    chk("first_grant_sel", sel, 1);
    rst_n = 0;
    req0 = 0;
    req1 = 0;
    tick;
    tick;
    rst_n = 1;
    tick;
    mon_en = 1;
    run_rounds(300);
    chk("sb_drained_a", sbq.size(), 0);
    mon_en = 0;
    addr0 = 32'h0040_0000;
    req0 = 1;
    tick;
    chk("g0_gnt0", gnt0, 1);
    chk("g0_addr", mem_addr, 32'h0040_0000);
    chk("g0_we", mem_we, 0);
    mem_ack = 1;
    rst_n = 0;
    tick;
    chk("rst_mid_gnt0", gnt0, 0);
    chk("rst_mid_done0", done0, 0);
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_err", err, 0);
    chk("rst_mid_sel", sel, 0);
    rst_n = 1;
    req0 = 0;
    mem_ack = 0;
    tick;
    last_owner = 0;
    run = 0;
    mon_en = 1;
    run_rounds(200);
    chk("sb_drained_b", sbq.size(), 0);
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
